// File: rtl/tern_xor_acc.sv
// tern_xor_acc: frames of ternary words folded trit-wise (XOR mod 3 / MIN / MAX) into one registered result.
// Optional TERN_PARITY_EN adds out_par, the mod-3 sum of the result trits.
module tern_xor_acc #(
    parameter int NTRITS = 4,
    parameter int W      = 2 * NTRITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
`ifdef TERN_PARITY_EN
    output logic [1:0]   out_par,
`endif
    output logic         out_err
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] acc, res;
    logic [1:0]   mode_q, op_mode;
    logic         err, bad, err_nxt, accept;

    // mode 01 MIN, 10 MAX, anything else is the per-trit mod-3 sum
    function automatic logic [1:0] trit_op(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return m == 2'b01 ? (a < b ? a : b) :
               m == 2'b10 ? (a > b ? a : b) :
               2'(s >= 3'd3 ? s - 3'd3 : s);
    endfunction

    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    assign op_mode   = state == IDLE ? mode : mode_q;

    always_comb begin
        res = '0;
        bad = 1'b0;
        for (int i = 0; i < NTRITS; i++) begin
            logic [1:0] t;
            t   = in_data[2*i +: 2] == 2'b11 ? 2'b00 : in_data[2*i +: 2];
            bad = bad | (in_data[2*i +: 2] == 2'b11);
            res[2*i +: 2] = state == IDLE ? t : trit_op(op_mode, acc[2*i +: 2], t);
        end
        err_nxt = (state == IDLE ? 1'b0 : err) | bad;
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = in_last ? HOLD : ACC;
        else if (state == HOLD && out_ready)
            state_nxt = IDLE;
    end

`ifdef TERN_PARITY_EN
    logic [1:0] par_nxt;
    always_comb begin
        par_nxt = 2'b00;
        for (int i = 0; i < NTRITS; i++)
            par_nxt = trit_op(2'b00, par_nxt, res[2*i +: 2]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            out_par <= '0;
        else if (accept && in_last)
            out_par <= par_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            err      <= 1'b0;
            mode_q   <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= res;
                err <= err_nxt;
                if (state == IDLE)
                    mode_q <= mode;
                if (in_last) begin
                    out_data <= res;
                    out_err  <= err_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_tern_xor_acc.sv
// tb_tern_xor_acc: directed frames with hand-computed results, checked by immediate assertions.
module tb_tern_xor_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [1:0] mode = '0;
    logic       in_ready, out_valid, out_err;
    logic [7:0] out_data;
`ifdef TERN_PARITY_EN
    logic [1:0] out_par;
`endif
    int checks = 0, errors = 0;

    tern_xor_acc #(.NTRITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef TERN_PARITY_EN
        .out_par(out_par),
`endif
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // called at a negedge; drives one beat across the next rising edge
    task automatic beat(input logic [7:0] d, input logic l, input logic [1:0] m);
        in_valid = 1'b1; in_data = d; in_last = l; mode = m;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_fall"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_ready_back"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        #1;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_err", {7'd0, out_err}, 8'd0);
        chk("rst_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        beat(8'b01_10_00_01, 1'b0, 2'b00);
        chk("xor_mid_valid", {7'd0, out_valid}, 8'd0);
        beat(8'b10_10_01_00, 1'b1, 2'b00);
        chk("xor_valid", {7'd0, out_valid}, 8'd1);
        chk("xor_data", out_data, 8'b00_01_01_01);
        chk("xor_err", {7'd0, out_err}, 8'd0);
`ifdef TERN_PARITY_EN
        chk("xor_par", {6'd0, out_par}, 8'd0);
`endif
        handshake("xor");

        beat(8'b10_01_00_10, 1'b0, 2'b01);
        beat(8'b01_10_10_10, 1'b1, 2'b10);
        chk("min_data", out_data, 8'b01_01_00_10);
        handshake("min");

        beat(8'b10_01_00_10, 1'b0, 2'b10);
        beat(8'b01_10_10_10, 1'b1, 2'b01);
        chk("max_data", out_data, 8'b10_10_10_10);

        in_valid = 1'b1; in_data = 8'b00_00_00_01; in_last = 1'b1; mode = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_data", out_data, 8'b10_10_10_10);
            chk("bp_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_valid", {7'd0, out_valid}, 8'd0);
        chk("bp_idle_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_next_valid", {7'd0, out_valid}, 8'd1);
        chk("bp_next_data", out_data, 8'b00_00_00_01);
        handshake("bp");

        beat(8'b11_01_10_00, 1'b1, 2'b00);
        chk("inv_data", out_data, 8'b00_01_10_00);
        chk("inv_err", {7'd0, out_err}, 8'd1);
        handshake("inv");
        beat(8'b00_00_00_10, 1'b1, 2'b00);
        chk("clean_err", {7'd0, out_err}, 8'd0);
        chk("clean_data", out_data, 8'b00_00_00_10);
        handshake("clean");

        beat(8'b00_00_00_01, 1'b0, 2'b00);
        beat(8'b00_00_11_01, 1'b1, 2'b00);
        chk("inv2_data", out_data, 8'b00_00_00_10);
        chk("inv2_err", {7'd0, out_err}, 8'd1);
        handshake("inv2");

        beat(8'b00_00_01_01, 1'b0, 2'b11);
        beat(8'b00_00_01_10, 1'b1, 2'b01);
        chk("rsv_data", out_data, 8'b00_00_10_00);
        handshake("rsv");

        beat(8'b10_10_10_01, 1'b1, 2'b00);
        chk("par_src_data", out_data, 8'b10_10_10_01);
`ifdef TERN_PARITY_EN
        chk("par_one", {6'd0, out_par}, 8'd1);
`endif
        handshake("par");

        beat(8'b00_00_00_01, 1'b0, 2'b00);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", {7'd0, out_valid}, 8'd0);
        chk("rstmid_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(8'b00_00_00_10, 1'b1, 2'b00);
        chk("rstmid_next", out_data, 8'b00_00_00_10);

        #1 rst_n = 1'b0;
        #1;
        chk("rsthold_valid", {7'd0, out_valid}, 8'd0);
        chk("rsthold_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
